// File: rtl/dice_pkg.sv
// ============================================================================
//  Module   : dice_pkg
//  Brief    : Die codes, FSM state type and roll helpers for the dice engine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dice_pkg;

    localparam logic [3:0] CODE_D4   = 4'h0;
    localparam logic [3:0] CODE_D6   = 4'h1;
    localparam logic [3:0] CODE_D8   = 4'h2;
    localparam logic [3:0] CODE_D10  = 4'h3;
    localparam logic [3:0] CODE_D12  = 4'h4;
    localparam logic [3:0] CODE_D20  = 4'h5;
    localparam logic [3:0] CODE_TEST = 4'h7;
    localparam logic [3:0] CODE_NONE = 4'hF;

    // Feedback taps b15, b13, b12, b10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_DONE = 2'd2
    } dice_state_e;

    // Side count for a code; TEST reports 20, anything not rollable reports 0
    function automatic logic [4:0] code_to_sides(input logic [3:0] code);
        case (code)
            CODE_D4:   code_to_sides = 5'd4;
            CODE_D6:   code_to_sides = 5'd6;
            CODE_D8:   code_to_sides = 5'd8;
            CODE_D10:  code_to_sides = 5'd10;
            CODE_D12:  code_to_sides = 5'd12;
            CODE_D20:  code_to_sides = 5'd20;
            CODE_TEST: code_to_sides = 5'd20;
            default:   code_to_sides = 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] roll_map(input logic [7:0] rnd, input logic [4:0] n);
        logic [4:0] m;
        if (n == 5'd0) begin
            roll_map = 5'd0;
        end else begin
            m        = 5'(rnd % {3'b000, n});
            roll_map = m + 5'd1;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
//  Module   : lfsr16
//  Brief    : 16-bit left-shifting Fibonacci LFSR with a non-zero seed.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);
    import dice_pkg::*;

    // An all-zero seed would lock the register, so it is replaced by 1
    localparam logic [15:0] c_seed = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= c_seed;
        end else if (en) begin
            r_q <= {r_q[14:0], ^(r_q & LFSR_TAPS)};
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/dice_roll_engine.sv
// ============================================================================
//  Module   : dice_roll_engine
//  Brief    : Turns encoder die-select presses into a spin animation and a
//             final 1..N roll for the display stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_roll_engine #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          SPIN_CYCLES = 16,
    parameter int          CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dieSelect,
    output logic [4:0] rollValue,
    output logic [4:0] dieSides,
    output logic       rollValid,
    output logic       busy
);
    import dice_pkg::*;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(SPIN_CYCLES - 1);

    logic [15:0]      w_lfsr;
    logic [4:0]       w_sides;
    logic             w_press;
    logic             w_is_test;
    logic             w_unused;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sel_s;
    logic [3:0]       r_sel_q;
    dice_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_value;
    logic [4:0]       r_sides;
    logic             r_valid;
    logic [4:0]       r_test_cnt;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (w_lfsr)
    );

    assign w_unused = &{1'b0, w_lfsr[15:8]};

    // A press is a fresh rollable code arriving straight after a release
    assign w_sides   = code_to_sides(r_sel_s);
    assign w_press   = (r_sel_q == CODE_NONE) && (w_sides != 5'd0);
    assign w_is_test = (r_sel_s == CODE_TEST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= CODE_NONE;
            r_sel_s    <= CODE_NONE;
            r_sel_q    <= CODE_NONE;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_value    <= 5'd0;
            r_sides    <= 5'd0;
            r_valid    <= 1'b0;
            r_test_cnt <= 5'd1;
        end else begin
            r_sync1 <= dieSelect;
            r_sel_s <= r_sync1;
            r_sel_q <= r_sel_s;
            r_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        if (w_is_test) begin
                            r_sides    <= 5'd20;
                            r_value    <= r_test_cnt;
                            r_valid    <= 1'b1;
                            r_test_cnt <= (r_test_cnt == 5'd20) ? 5'd1 : r_test_cnt + 5'd1;
                        end else begin
                            r_sides <= w_sides;
                            r_cnt   <= '0;
                            r_state <= ST_SPIN;
                        end
                    end
                end
                ST_SPIN: begin
                    // The last spin value doubles as the final roll shown in DONE
                    r_value <= roll_map(w_lfsr[7:0], r_sides);
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rollValue = r_value;
    assign dieSides  = r_sides;
    assign rollValid = r_valid;
    assign busy      = (r_state == ST_SPIN);

endmodule

`default_nettype wire

// File: tb/tb_dice_roll_engine.sv
// ============================================================================
//  Module   : tb_dice_roll_engine
//  Brief    : Scoreboard bench for dice_roll_engine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dice_roll_engine;

    localparam int SPIN = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  dieSelect = 4'hF;
    logic [4:0]  rollValue;
    logic [4:0]  dieSides;
    logic        rollValid;
    logic        busy;
    logic [15:0] lfsr0_q;

    always #5 clk = ~clk;

    dice_roll_engine #(
        .SEED        (16'hACE1),
        .SPIN_CYCLES (SPIN),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dieSelect (dieSelect),
        .rollValue (rollValue),
        .dieSides  (dieSides),
        .rollValid (rollValid),
        .busy      (busy)
    );

    lfsr16 #(
        .SEED (16'h0000)
    ) u_lfsr0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr0_q)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference LFSR, stepped alongside the design from the same reset
    function automatic logic [15:0] m_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int m_map(input logic [15:0] s, input int n);
        return (int'(s[7:0]) % n) + 1;
    endfunction

    logic [15:0] m_lfsr;
    int          cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_next(m_lfsr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int sides;
        int at;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int   tcnt      = 1;
    int   n_valid   = 0;
    int   last_val  = 0;
    int   busy_run  = 0;
    int   zero_seen = 0;
    logic busy_seen = 1'b0;
    logic [4:1] hit4 = '0;
    logic [6:1] hit6 = '0;

    // Called at a negedge just before the press code is driven
    function automatic void expect_roll(input int sides);
        logic [15:0] s;
        exp_t        e;
        s = m_lfsr;
        repeat (SPIN + 2) s = m_next(s);
        e.val   = m_map(s, sides);
        e.sides = sides;
        e.at    = cyc + SPIN + 3;
        sbq.push_back(e);
    endfunction

    function automatic void expect_test();
        exp_t e;
        e.val   = tcnt;
        e.sides = 20;
        e.at    = cyc + 3;
        sbq.push_back(e);
        tcnt = (tcnt == 20) ? 1 : tcnt + 1;
    endfunction

    task automatic press(input logic [3:0] code, input int hold, input int sides);
        @(negedge clk);
        if (code == 4'h7)      expect_test();
        else if (sides != 0)   expect_roll(sides);
        dieSelect = code;
        repeat (hold) @(negedge clk);
        dieSelect = 4'hF;
        repeat (SPIN + 6) @(negedge clk);
    endtask

    // Monitor: pops and compares whenever the design presents a result
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (lfsr0_q == 16'h0000) zero_seen++;
            if (busy) begin
                busy_seen = 1'b1;
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, SPIN);
                busy_run = 0;
            end
            if (rollValid) begin
                n_valid++;
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: rollValue=%0d dieSides=%0d with nothing expected", rollValue, dieSides);
                end else begin
                    m_e = sbq.pop_front();
                    check("roll_value", int'(rollValue), m_e.val);
                    check("die_sides", int'(dieSides), m_e.sides);
                    check("valid_cycle", cyc, m_e.at);
                    check("in_range", int'(rollValue >= 5'd1 && rollValue <= dieSides), 1);
                    if (dieSides == 5'd4 && rollValue >= 5'd1 && rollValue <= 5'd4) hit4[rollValue] = 1'b1;
                    if (dieSides == 5'd6 && rollValue >= 5'd1 && rollValue <= 5'd6) hit6[rollValue] = 1'b1;
                    last_val = int'(rollValue);
                end
            end
        end
    end

    int sides_tab [0:5] = '{4, 6, 8, 10, 12, 20};

    initial begin
        int v0;
        int k;

        // Reset and quiet idle
        rst_n     = 1'b0;
        dieSelect = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_rollValue", int'(rollValue), 0);
        check("rst_dieSides", int'(dieSides), 0);
        check("rst_rollValid", int'(rollValid), 0);
        check("rst_busy", int'(busy), 0);
        check("seed0_reset", int'(lfsr0_q), 16'h0001);
        rst_n = 1'b1;
        @(negedge clk);
        check("lfsr_first_step", int'(dut.u_lfsr.q), 16'h59C3);
        check("seed0_first_step", int'(lfsr0_q), 16'h0002);
        repeat (50) @(negedge clk);
        check("idle_rollValue", int'(rollValue), 0);
        check("idle_dieSides", int'(dieSides), 0);
        check("idle_no_valid", n_valid, 0);

        // Test mode: 1..20 then wrap to 1, never busy
        busy_seen = 1'b0;
        for (int i = 0; i < 21; i++) press(4'h7, 2, 20);
        check("test_wrap_value", last_val, 1);
        check("test_never_busy", int'(busy_seen), 0);

        // D6 held 40 cycles, value held through idle
        press(4'h1, 40, 6);
        repeat (100) @(negedge clk);
        check("held_value", int'(rollValue), last_val);
        check("held_sides", int'(dieSides), 6);

        // 200 rolls for every die
        for (int c = 0; c < 6; c++) begin
            for (int r = 0; r < 200; r++) press(4'(c), 2, sides_tab[c]);
        end
        check("d4_faces", int'(hit4), 4'hF);
        check("d6_faces", int'(hit6), 6'h3F);

        // Held button fires once
        v0 = n_valid;
        press(4'h2, 100, 8);
        check("hold_one_pulse", n_valid - v0, 1);

        // Invalid codes never roll
        v0 = n_valid;
        press(4'h6, 3, 0);
        press(4'h9, 3, 0);
        check("invalid_no_pulse", n_valid - v0, 0);

        // Press during SPIN is ignored
        v0 = n_valid;
        @(negedge clk);
        expect_roll(6);
        dieSelect = 4'h1;
        repeat (3) @(negedge clk);
        dieSelect = 4'hF;
        repeat (5) @(negedge clk);
        dieSelect = 4'h3;
        repeat (4) @(negedge clk);
        dieSelect = 4'hF;
        repeat (30) @(negedge clk);
        check("spin_press_ignored", n_valid - v0, 1);

        // Reset in the middle of a spin
        v0 = n_valid;
        @(negedge clk);
        dieSelect = 4'h1;
        repeat (3) @(negedge clk);
        dieSelect = 4'hF;
        k = 0;
        while (!busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("spin_started", int'(busy), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rollValue", int'(rollValue), 0);
        check("midrst_dieSides", int'(dieSides), 0);
        check("midrst_rollValid", int'(rollValid), 0);
        check("midrst_busy", int'(busy), 0);
        tcnt = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_no_pulse", n_valid - v0, 0);

        // Normal operation after reset, test counter restarted
        press(4'h5, 2, 20);
        press(4'h7, 2, 20);
        check("test_after_reset", last_val, 1);

        k = 0;
        while (sbq.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("pending_results", sbq.size(), 0);
        check("seed0_never_zero", zero_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
